// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the sequential ALU: opcodes, FSM states
// and the classification of ops that take the iterative datapath.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0100,
        OP_SUB   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_MULHU = 4'b1001,
        OP_DIVU  = 4'b1010,
        OP_REMU  = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // True for the multiply/divide family; divide-by-zero is filtered
    // separately by the caller because it resolves on the fast path.
    function automatic logic is_iterative(input logic [3:0] op);
        logic iter;
        case (op)
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: iter = 1'b1;
            default:                            iter = 1'b0;
        endcase
        return iter;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) and restoring divide.
// Both share a 2*WIDTH accumulator: {hi, lo} is the product for multiply,
// {remainder, quotient} for divide. The lo/hi outputs carry the value the
// accumulator takes on the current step, so the caller captures the final
// result on the same edge that performs the last step (flagged by last).
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   b_r;
    logic               div_r;
    logic               run_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [2*WIDTH-1:0] step_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     part_s;
    logic [WIDTH:0]     trial_s;

    // Next accumulator value for one multiply or divide step.
    always_comb begin
        step_s  = acc_r;
        sum_s   = {(WIDTH+1){1'b0}};
        part_s  = acc_r[2*WIDTH-1:WIDTH-1];
        trial_s = part_s - {1'b0, b_r};
        if (div_r) begin
            // part_s < 2*b always, so the difference never exceeds WIDTH
            // bits and the top bit is a clean borrow indicator.
            if (!trial_s[WIDTH]) begin
                step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {part_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
            end else begin
                sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
            end
            step_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    assign lo   = step_s[WIDTH-1:0];
    assign hi   = step_s[2*WIDTH-1:WIDTH];
    assign last = run_r && (cnt_r == CNT_W'(WIDTH-1));

    // Operand load on start, then one step per cycle; the counter stops
    // at WIDTH-1 instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {(2*WIDTH){1'b0}};
            b_r   <= {WIDTH{1'b0}};
            div_r <= 1'b0;
            run_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            acc_r <= {{WIDTH{1'b0}}, a};
            b_r   <= b;
            div_r <= op_is_div;
            run_r <= 1'b1;
            cnt_r <= {CNT_W{1'b0}};
        end else if (run_r) begin
            acc_r <= step_s;
            if (last) begin
                run_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU. Logic/arithmetic ops, illegal opcodes and
// divide-by-zero resolve in the accept cycle; multiply/divide run through
// muldiv_iter for WIDTH cycles. Results and flags sit in registers that
// only change on the edge entering DONE.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUoperation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    alu_state_e       state_r;
    alu_state_e       state_nxt_s;
    logic             sel_hi_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             dbz_r;
    logic             ill_r;

    logic             accept_s;
    logic             b_zero_s;
    logic             is_div_s;
    logic             iter_s;
    logic [WIDTH-1:0] fast_res_s;
    logic             fast_dbz_s;
    logic             fast_ill_s;
    logic [WIDTH-1:0] iter_lo_s;
    logic [WIDTH-1:0] iter_hi_s;
    logic [WIDTH-1:0] iter_res_s;
    logic             iter_last_s;

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign out_valid = (state_r == ST_DONE);
    assign accept_s  = in_valid && in_ready;
    assign b_zero_s  = (operand2 == {WIDTH{1'b0}});
    assign is_div_s  = (ALUoperation == OP_DIVU) || (ALUoperation == OP_REMU);
    assign iter_s    = is_iterative(ALUoperation) && !(is_div_s && b_zero_s);

    assign ALUresult   = result_r;
    assign zero        = zero_r;
    assign div_by_zero = dbz_r;
    assign illegal_op  = ill_r;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept_s && iter_s),
        .op_is_div (is_div_s),
        .a         (operand1),
        .b         (operand2),
        .lo        (iter_lo_s),
        .hi        (iter_hi_s),
        .last      (iter_last_s)
    );

    assign iter_res_s = sel_hi_r ? iter_hi_s : iter_lo_s;

    // Single-cycle results, including the divide-by-zero conventions.
    always_comb begin
        fast_res_s = {WIDTH{1'b0}};
        fast_dbz_s = 1'b0;
        fast_ill_s = 1'b0;
        case (ALUoperation)
            OP_AND:  fast_res_s = operand1 & operand2;
            OP_OR:   fast_res_s = operand1 | operand2;
            OP_ADD:  fast_res_s = operand1 + operand2;
            OP_XOR:  fast_res_s = operand1 ^ operand2;
            OP_SUB:  fast_res_s = operand1 - operand2;
            OP_SLTU: fast_res_s = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            OP_MUL, OP_MULHU: fast_res_s = {WIDTH{1'b0}};
            OP_DIVU: begin
                fast_res_s = {WIDTH{1'b1}};
                fast_dbz_s = b_zero_s;
            end
            OP_REMU: begin
                fast_res_s = operand1;
                fast_dbz_s = b_zero_s;
            end
            default: fast_ill_s = 1'b1;
        endcase
    end

    // Next-state logic; a DONE-cycle accept replaces the consumed result.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = iter_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (iter_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = iter_s ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Remember at accept whether the upper half (MULHU/REMU) is wanted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_hi_r <= 1'b0;
        end else if (accept_s) begin
            sel_hi_r <= (ALUoperation == OP_MULHU) || (ALUoperation == OP_REMU);
        end
    end

    // Result and flag registers, loaded only on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            dbz_r    <= 1'b0;
            ill_r    <= 1'b0;
        end else if (accept_s && !iter_s) begin
            result_r <= fast_res_s;
            zero_r   <= (fast_res_s == {WIDTH{1'b0}});
            dbz_r    <= fast_dbz_s;
            ill_r    <= fast_ill_s;
        end else if ((state_r == ST_BUSY) && iter_last_s) begin
            result_r <= iter_res_s;
            zero_r   <= (iter_res_s == {WIDTH{1'b0}});
            dbz_r    <= 1'b0;
            ill_r    <= 1'b0;
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle datapath ALU, for the multi-cycle processor variant. Executes the logic/arithmetic ops in one cycle and unsigned multiply/divide/remainder iteratively, one bit per cycle. Operands arrive on a valid/ready input channel and results leave on a registered valid/ready output channel. It sits between the register-read stage and writeback, with stall control driven by the handshakes.

## Interface
- WIDTH, 32, operand/result width; legal range 2..64.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block can accept an op this cycle
- ALUoperation  input  4  opcode (alu_op_e)
- operand1  input  WIDTH  first operand; dividend
- operand2  input  WIDTH  second operand; divisor
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes the result this cycle
- ALUresult  output  WIDTH  registered result
- zero  output  1  ALUresult == 0, valid for every op
- div_by_zero  output  1  DIVU/REMU issued with operand2 == 0
- illegal_op  output  1  opcode not in alu_op_e

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH); 0100 XOR; 0110 SUB (wraps); 0111 SLTU (result 1 if operand1 < operand2, else 0).
  - 1000 MUL (low WIDTH bits of product); 1001 MULHU (high WIDTH bits); 1010 DIVU; 1011 REMU.
- Fast path: all logic/add/sub/slt ops, illegal opcodes, and DIVU/REMU with operand2 == 0.
  - Illegal opcode: ALUresult 0, zero 1, illegal_op 1.
  - DIVU by zero: quotient all ones. REMU by zero: result is operand1. div_by_zero 1 in both cases.
- Iterative path: MUL/MULHU use shift-add on a 2*WIDTH accumulator; DIVU/REMU use restoring division. Each takes exactly WIDTH BUSY cycles.
- FSM states:
  - IDLE -> BUSY on accept of an iterative op.
  - IDLE -> DONE on accept of a fast op.
  - BUSY -> DONE when the iteration counter reaches WIDTH-1.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> BUSY/DONE on out_ready with a same-cycle accept (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready). in_ready is 0 throughout BUSY.
- Accept = in_valid && in_ready. Operands and op are captured at the accept edge; input changes after accept have no effect.
- out_valid = (state == DONE).
  - ALUresult, zero, div_by_zero and illegal_op are all registered and held stable while out_valid && !out_ready.
  - These outputs update only on the edge that enters DONE.

## Timing
- Reset: async on rst_n low. State IDLE; out_valid 0; in_ready 1 after release; ALUresult 0; zero 0; div_by_zero 0; illegal_op 0; counter 0.
- Reset asserted mid-BUSY aborts the op with no output. Reset during DONE discards the pending result.
- Fast-op latency: for an accept at edge k, out_valid is high after edge k+1.
- Iterative latency: for an accept at edge k, out_valid is high after edge k+WIDTH+1.
- Throughput: one fast op per cycle when out_ready is held high. Iterative ops run back-to-back with a gap of 0 cycles between the DONE cycle and the next accept.
- Counter width: $clog2(WIDTH). It resets to 0 on each accept and does not wrap during an op.
- A same-cycle out_ready and in_valid in DONE must neither drop nor duplicate a result.

## Structure
- Package seq_alu_pkg:
  - alu_op_e: 4-bit enum of the opcodes above.
  - alu_state_e: IDLE, BUSY, DONE.
  - is_iterative(op) function.
- Sub-module muldiv_iter, parameter WIDTH:
  - Inputs: start, op_is_div, a, b.
  - Outputs: lo/hi or quotient/remainder, last.
  - Owns the accumulator and counter.
- The top level holds the FSM, fast-path logic, result/flag registers and handshake.

## Test plan
- Reset then ADD with operand1=0xFFFFFFFF, operand2=1 (WIDTH=32) -> after 1 cycle: out_valid, ALUresult 0, zero 1.
- MUL 0x10000 x 0x10000, then MULHU with the same operands -> MUL result 0, MULHU result 1. out_valid appears exactly 33 edges after each accept; in_ready is 0 in between.
- DIVU 100/7, then REMU 100/7, then DIVU 5/0 and REMU 5/0:
  - 100/7 -> 14; 100 rem 7 -> 2.
  - 5/0 -> 0xFFFFFFFF with div_by_zero 1, latency 1.
  - 5 rem 0 -> 5 with div_by_zero 1, latency 1.
- Backpressure: hold out_ready 0 for 5 cycles after SUB 3-5 -> ALUresult 0xFFFFFFFE held stable, in_ready 0. Then pulse out_ready together with in_valid carrying OR -> no result lost or duplicated.
- Opcode 1111 -> illegal_op 1, ALUresult 0. Assert rst_n low during a DIVU BUSY cycle -> outputs at reset values immediately, no out_valid afterwards.
- WIDTH=8 instance: random fast and iterative ops against the reference model with random out_ready stalls.
